// File: rtl/redux_pkg.sv
// Shared defaults and types for the 2x upscaler that rebuilds the reduced raster.
package redux_pkg;

    localparam int unsigned PIX_W_DEF = 8;
    // 160x120 full-resolution frame halved in each direction
    localparam int unsigned IN_W_DEF  = 80;
    localparam int unsigned IN_H_DEF  = 60;

    typedef enum logic [0:0] {StLoad, StEmit} redux_state_e;

    // Counter width for a range of n values, never below one bit
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/redux_line_buf.sv
// One-line pixel store: synchronous write port, combinational read port.
module redux_line_buf #(
    parameter int unsigned DEPTH = 80,
    parameter int unsigned PIX_W = 8,
    parameter int unsigned AW    = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/redux_upscale_2x.sv
// 2x nearest-neighbour upscaler: buffers one reduced line, then emits it twice at double width.
module redux_upscale_2x
    import redux_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned IN_H  = IN_H_DEF,
    parameter int unsigned PIX_W = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_sof,
    output logic             m_eol
);

    localparam int unsigned WCOL_W = cnt_w(IN_W);
    localparam int unsigned OCOL_W = cnt_w(2 * IN_W);
    localparam int unsigned ROW_W  = cnt_w(IN_H);

    localparam logic [WCOL_W-1:0] WCOL_LAST = WCOL_W'(IN_W - 1);
    localparam logic [OCOL_W-1:0] OCOL_LAST = OCOL_W'(2 * IN_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IN_H - 1);

    redux_state_e      state_q, state_d;
    logic [WCOL_W-1:0] wcol_q, wcol_d;
    logic [OCOL_W-1:0] ocol_q, ocol_d;
    logic              rep_q, rep_d;
    logic [ROW_W-1:0]  row_q, row_d;

    logic              buf_we;
    logic [WCOL_W-1:0] buf_raddr;
    logic [PIX_W-1:0]  buf_rdata;

    // Each buffered pixel covers two adjacent output columns
    assign buf_raddr = WCOL_W'(ocol_q >> 1);

    redux_line_buf #(
        .DEPTH (IN_W),
        .PIX_W (PIX_W),
        .AW    (WCOL_W)
    ) u_line_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wcol_q),
        .wdata (s_data),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLoad;
            wcol_q  <= '0;
            ocol_q  <= '0;
            rep_q   <= 1'b0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            wcol_q  <= wcol_d;
            ocol_q  <= ocol_d;
            rep_q   <= rep_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcol_d  = wcol_q;
        ocol_d  = ocol_q;
        rep_d   = rep_q;
        row_d   = row_q;
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_sof   = 1'b0;
        m_eol   = 1'b0;
        buf_we  = 1'b0;

        unique case (state_q)
            StLoad: begin
                s_ready = !rst;
                buf_we  = s_valid && !rst;
                if (s_valid) begin
                    if (wcol_q == WCOL_LAST) begin
                        wcol_d  = '0;
                        state_d = StEmit;
                    end else begin
                        wcol_d = wcol_q + 1'b1;
                    end
                end
            end
            StEmit: begin
                m_valid = 1'b1;
                m_data  = buf_rdata;
                m_eol   = (ocol_q == OCOL_LAST);
                m_sof   = (ocol_q == '0) && !rep_q && (row_q == '0);
                if (m_ready) begin
                    if (m_eol) begin
                        ocol_d = '0;
                        if (!rep_q) begin
                            rep_d = 1'b1;
                        end else begin
                            rep_d   = 1'b0;
                            state_d = StLoad;
                            row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                        end
                    end else begin
                        ocol_d = ocol_q + 1'b1;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

endmodule

// File: doc/redux_upscale_2x.md
Name: redux_upscale_2x

Overview:
- Inverse of the 2x2 averaging reduction: expands a reduced 8-bit greyscale raster to full resolution by 2x nearest-neighbour replication.
- Each input pixel becomes a 2x2 block of identical output pixels, so IN_W x IN_H in gives 2*IN_W x 2*IN_H out.
- Streaming, valid/ready on both sides. Sits after the reduction path, so a full-resolution image can be rebuilt and compared against the original frame.

Parameters:
- IN_W, 80, reduced image width in pixels.
- IN_H, 60, reduced image height in lines.
- PIX_W, 8, pixel width in bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  block accepts an input pixel.
- s_data  in  PIX_W  reduced pixel, raster order.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream accepts an output pixel.
- m_data  out  PIX_W  expanded pixel, raster order.
- m_sof  out  1  asserted with the first output pixel of a frame.
- m_eol  out  1  asserted with the last output pixel of each output line.

Behaviour:
- Reset (asynchronous, active-high):
  - state = LOAD; all counters = 0.
  - m_valid = 0, m_sof = 0, m_eol = 0, m_data = 0.
  - s_ready = 0 while rst is high.
  - Line buffer contents are don't-care.
  - Reset mid-line or mid-frame discards the partial line/frame. The first pixel accepted after reset is pixel (0,0).
- Transfer rule: a transfer occurs when valid && ready at a rising clk edge.
  - Once m_valid is asserted, m_valid, m_data, m_sof and m_eol stay stable until the m_ready handshake.
- State LOAD:
  - s_ready = 1 and m_valid = 0.
  - Each accepted pixel is written to buf[wcol] and wcol increments.
  - On the accept with wcol == IN_W-1: wcol goes to 0 and the next state is EMIT.
- State EMIT:
  - s_ready = 0 and m_valid = 1.
  - m_data = buf[ocol>>1], where ocol runs 0..2*IN_W-1.
  - ocol advances only on an m_ready handshake.
  - rep (0/1) selects the first or second copy of the output line.
  - m_eol = (ocol == 2*IN_W-1).
  - m_sof = (ocol == 0 && rep == 0 && row == 0).
  - On the handshake with m_eol and rep == 0: ocol goes to 0, rep goes to 1, state stays EMIT.
  - On the handshake with m_eol and rep == 1: rep goes to 0 and the next state is LOAD. row increments and wraps to 0 after IN_H-1, which gives the frame boundary.
- Latency and throughput:
  - First output pixel is valid the cycle after the IN_W-th input pixel of a line is accepted.
  - m_valid and s_ready are never both 1.
  - With m_ready held at 1: IN_W load cycles + 4*IN_W emit cycles per input line.
- Back-pressure: m_ready low in EMIT freezes all counters and outputs. s_valid low in LOAD freezes wcol.
- Arithmetic: counters are sized with $clog2 of their range. Indices never exceed their range; wrap is explicit at the terminal count.

Decomposition:
- Package redux_pkg:
  - PIX_W default.
  - IN_W/IN_H defaults, 80/60 (derived from the 160x120 full-resolution frame).
  - State enum typedef {LOAD, EMIT}.
- Sub-module redux_line_buf: IN_W x PIX_W register array.
  - One synchronous write port (we, waddr, wdata).
  - One combinational read port (raddr, rdata).
- All control (state, wcol, ocol, rep, row) stays in the top module.

Test Plan (IN_W=4, IN_H=2 unless noted):
- Single frame, m_ready=1 throughout:
  - Stimulus: input 10,20,30,40 / 50,60,70,80.
  - Expected output lines: 10,10,20,20,30,30,40,40 twice, then 50,50,60,60,70,70,80,80 twice (32 pixels total).
  - m_sof only on the first pixel; m_eol on every 8th pixel.
- Back-pressure:
  - Stimulus: m_ready toggles 1,0,0,1 during EMIT.
  - Expected: m_data/m_sof/m_eol stay stable while m_ready=0; the same 32-pixel sequence with no loss or duplication; s_ready=0 throughout EMIT.
- Input gaps:
  - Stimulus: s_valid low for 3 cycles between pixels 2 and 3 in LOAD.
  - Expected: wcol holds; output identical to scenario 1.
- Async reset mid-frame:
  - Stimulus: rst pulsed (not aligned to clk) while emitting the second copy of line 0, then a fresh frame 1,2,3,4 / 5,6,7,8.
  - Expected: m_valid=0 immediately on reset; output restarts with m_sof on pixel value 1.
- Frame wrap:
  - Stimulus: two back-to-back frames.
  - Expected: row wraps 1->0; m_sof asserted exactly twice; the second frame's first pixel follows the first frame's last m_eol.
- Default parameters (80x60):
  - Stimulus: ramp image, pixel = (x+y) mod 256.
  - Expected: output pixel (X,Y) == ((X>>1)+(Y>>1)) mod 256 for all 160x120 pixels; 19200 handshakes.
